// File: rtl/sprite_loader.sv
// Streams RGBA pixel words into a vram write port at consecutive addresses,
// buffering through a small FIFO and only writing while vertical blanking is active.
module sprite_loader #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 13,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              vblank,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err_len
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic              r_vb_meta;
  logic              r_vb_sync;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_acc_cnt;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic              r_err_len;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic [DATA_W-1:0] r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    r_wptr;
  logic [PTR_W:0]    r_rptr;

  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic              w_s_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_start_ok;
  logic [ADDR_W-1:0] w_acc_inc;
  logic              w_at_len;
  logic              w_err_set;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_fifo_empty = (r_wptr == r_rptr);
  assign w_fifo_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                        (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);

  assign w_start_ok = (r_state == ST_IDLE) && start;
  assign w_s_ready  = (r_state == ST_RUN) && !w_fifo_full;
  assign w_push     = s_valid && w_s_ready;
  assign w_pop      = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) && r_vb_sync && !w_fifo_empty;
  assign w_acc_inc  = r_acc_cnt + ADDR_W'(1);
  assign w_at_len   = (w_acc_inc == r_len);
  // A mismatch is an s_last that arrives early, or the final word arriving without it.
  assign w_err_set  = w_push && (s_last != w_at_len);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = (length == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_push && (s_last || w_at_len)) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Empty here means the last pop's write is on the port this cycle.
        if (w_fifo_empty) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_state   <= ST_IDLE;
      r_vb_meta <= 1'b0;
      r_vb_sync <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_vb_meta <= vblank;
      r_vb_sync <= r_vb_meta;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_base    <= '0;
      r_len     <= '0;
      r_acc_cnt <= '0;
      r_wr_cnt  <= '0;
      r_err_len <= 1'b0;
    end else if (w_start_ok) begin
      r_base    <= base_addr;
      r_len     <= length;
      r_acc_cnt <= '0;
      r_wr_cnt  <= '0;
      r_err_len <= 1'b0;
    end else begin
      if (w_push) r_acc_cnt <= w_acc_inc;
      if (w_pop) r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
      if (w_err_set) r_err_len <= 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (w_push) begin
      r_fifo_mem[r_wptr[PTR_W-1:0]] <= s_data;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (PTR_W+1)'(1);
      if (w_pop) r_rptr <= r_rptr + (PTR_W+1)'(1);
      r_wr_en <= w_pop;
      if (w_pop) begin
        r_wr_addr <= r_base + r_wr_cnt;
        r_wr_data <= r_fifo_mem[r_rptr[PTR_W-1:0]];
      end
    end
  end

  assign s_ready = w_s_ready;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign busy    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done    = (r_state == ST_DONE);
  assign err_len = r_err_len;

endmodule

// File: tb/tb_sprite_loader.sv
// Randomized scoreboard bench for sprite_loader: jobs push expected vram writes,
// a monitor pops and compares each write the loader issues.
module tb_sprite_loader;

  localparam int AW = 15;
  localparam int DW = 13;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] length = '0;
  logic          vblank = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          err_len;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic vb_d1 = 1'b0, vb_d2 = 1'b0, vb_d3 = 1'b0;

  exp_t exp_q[$];
  int   wr_total = 0;
  int   done_cnt = 0;
  int   last_wr_cyc = -10;
  int   first_wr_cyc = -1;
  int   done_cyc = -1;
  int   cur_exp_n = 0;

  sprite_loader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(16)) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .vblank    (vblank),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err_len   (err_len)
  );

  always #5 clk = ~clk;

  // vblank history: after edge e, vb_d3 holds the value sampled at edge e-2.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    vb_d1 <= vblank;
    vb_d2 <= vb_d1;
    vb_d3 <= vb_d2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n) begin
        if (wr_en) begin
          chk("wr_during_blank", {31'd0, vb_d3}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h expected no write", wr_addr, wr_data);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {17'd0, wr_addr}, {17'd0, e.addr});
            chk("wr_data", {19'd0, wr_data}, {19'd0, e.data});
          end
          wr_total++;
          last_wr_cyc = cyc;
          if (first_wr_cyc < 0) first_wr_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          chk("done_busy_low", {31'd0, busy}, 32'd0);
          chk("done_no_wr", {31'd0, wr_en}, 32'd0);
          if (cur_exp_n > 0) chk("done_after_last_wr", cyc - last_wr_cyc, 32'd1);
        end
      end
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    chk({tag, "_wr_addr"}, {17'd0, wr_addr}, 32'd0);
    chk({tag, "_wr_data"}, {19'd0, wr_data}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err_len"}, {31'd0, err_len}, 32'd0);
  endtask

  // mode: 0 vblank high, 1 low until loop cycle vb_raise, 2 random toggling.
  task automatic run_job(input logic [AW-1:0] base, input int len, input int last_pos,
                         input int mode, input int vb_raise, input int gap,
                         input bit poke, input bit gate_chk);
    logic [DW-1:0] words[$];
    int n_exp, idx, d0, w0, start_cyc, raise_cyc, post;
    bit err_exp, fin;
    idx = 0; raise_cyc = -1; post = -1; fin = 0;
    // Job length is truncated by an early s_last; any mismatch flags err_len.
    n_exp   = (len == 0) ? 0 : ((last_pos >= 1 && last_pos < len) ? last_pos : len);
    err_exp = (len != 0) && (last_pos != len);
    for (int i = 0; i < len + 4; i++) words.push_back(DW'($urandom));
    for (int i = 0; i < n_exp; i++) exp_q.push_back('{addr: base + AW'(i), data: words[i]});
    cur_exp_n = n_exp; d0 = done_cnt; w0 = wr_total; first_wr_cyc = -1;

    @(negedge clk);
    vblank = (mode == 1) ? 1'b0 : 1'b1;
    @(negedge clk);
    start = 1'b1; base_addr = base; length = AW'(len); start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, (len != 0) ? 32'd1 : 32'd0);

    for (int k = 0; k < 3000 && !fin; k++) begin
      if (mode == 1) begin
        vblank = (k >= vb_raise);
        if (k == vb_raise) raise_cyc = cyc;
      end else if (mode == 2 && $urandom_range(0, 5) == 0) begin
        vblank = ~vblank;
      end
      if (gate_chk && k == vb_raise - 5) begin
        chk("gate_accepted", idx, 32'd16);
        chk("gate_s_ready_full", {31'd0, s_ready}, 32'd0);
        chk("gate_no_writes", wr_total - w0, 32'd0);
      end
      if (poke && k == 5 && busy) begin
        start = 1'b1; base_addr = ~base; length = AW'(3);
      end else begin
        start = 1'b0;
      end
      if (idx < words.size() && $urandom_range(0, 99) >= gap) begin
        s_valid = 1'b1; s_data = words[idx]; s_last = (idx == last_pos - 1);
        if (s_ready) idx++;
      end else begin
        s_valid = 1'b0; s_last = 1'b0;
      end
      if (post < 0 && done_cnt != d0) post = 3;
      @(negedge clk);
      if (post > 0) begin
        post--;
        if (post == 0) fin = 1;
      end
    end
    s_valid = 1'b0; s_last = 1'b0; start = 1'b0;

    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL job_timeout: got no done within 3000 cycles expected done (base=0x%0h len=%0d)", base, len);
    end
    chk("accepted_words", idx, n_exp);
    chk("err_len", {31'd0, err_len}, {31'd0, err_exp});
    chk("writes_left", exp_q.size(), 32'd0);
    chk("done_pulses", done_cnt - d0, 32'd1);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    if (len == 0) begin
      chk("len0_no_write", wr_total - w0, 32'd0);
      chk("len0_done_latency", {31'd0, ((done_cyc - start_cyc) inside {1, 2})}, 32'd1);
    end
    if (gate_chk) chk("gate_first_write_delay", first_wr_cyc - raise_cyc, 32'd3);
    exp_q.delete();
    $display("job base=0x%04h len=%0d last=%0d mode=%0d accepted=%0d writes=%0d err_len=%0b",
             base, len, last_pos, mode, idx, wr_total - w0, err_len);
  endtask

  task automatic reset_mid_job();
    logic [DW-1:0] w[10];
    int idx, w0;
    idx = 0; w0 = wr_total; cur_exp_n = 10;
    for (int i = 0; i < 10; i++) begin
      w[i] = DW'($urandom);
      exp_q.push_back('{addr: 15'h02A0 + AW'(i), data: w[i]});
    end
    @(negedge clk);
    vblank = 1'b1; start = 1'b1; base_addr = 15'h02A0; length = AW'(10);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 200 && (wr_total - w0) < 5; k++) begin
      if (idx < 10) begin
        s_valid = 1'b1; s_data = w[idx]; s_last = (idx == 9);
        if (s_ready) idx++;
      end else begin
        s_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("midreset_writes_before", {31'd0, (wr_total - w0) >= 5}, 32'd1);
    #3 rst_n = 1'b0;
    #1 reset_checks("midreset");
    exp_q.delete();
    s_valid = 1'b0; s_last = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("job base=0x02a0 len=10 interrupted by reset after %0d writes", wr_total - w0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_job(15'h0100, 8, 8, 0, 0, 0, 1'b0, 1'b0);
    run_job(15'h1234, 20, 20, 1, 40, 0, 1'b0, 1'b1);
    run_job(15'h0400, 10, 6, 0, 0, 0, 1'b0, 1'b0);
    run_job(15'h7FFE, 4, 0, 0, 0, 0, 1'b0, 1'b0);
    run_job(15'h0200, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    run_job(15'h0300, 30, 30, 1, 40, 0, 1'b1, 1'b0);
    reset_mid_job();
    run_job(15'h0555, 7, 7, 0, 0, 0, 1'b0, 1'b0);

    for (int j = 0; j < 25; j++) begin
      int len, lp, sel;
      len = $urandom_range(1, 40);
      sel = $urandom_range(0, 2);
      lp  = (sel == 0) ? 0 : ((sel == 1) ? $urandom_range(1, len + 3) : len);
      run_job(AW'($urandom), len, lp, 2 * $urandom_range(0, 1), 0, 30, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
